// File: rtl/aes_pkg.sv
// Shared AES types for the AddRoundKey engine: block type, FSM states and a
// lane-width legality check used at elaboration.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XOR  = 2'd1,
    HOLD = 2'd2
  } ark_state_t;

  // A lane must divide the block evenly into a power-of-two number of beats.
  function automatic bit lane_w_valid(input int lane_w);
    return (lane_w == 8) || (lane_w == 16) || (lane_w == 32) ||
           (lane_w == 64) || (lane_w == 128);
  endfunction

endpackage

// File: rtl/round_key_bank.sv
// Round-key register file: one write port, one combinational read port with
// write-first bypass, cleared by asynchronous reset.
module round_key_bank
  import aes_pkg::*;
#(
  parameter  int NUM_KEYS = 15,
  localparam int KIDX_W   = $clog2(NUM_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [KIDX_W-1:0] wr_idx_i,
  input  aes_block_t        wr_data_i,
  input  logic [KIDX_W-1:0] rd_idx_i,
  output aes_block_t        rd_data_o,
  output logic              rd_in_range_o
);

  localparam logic [KIDX_W:0] NK = (KIDX_W+1)'(NUM_KEYS);

  aes_block_t bank_q [NUM_KEYS];
  logic       wr_in_range;
  logic       rd_in_range;

  assign wr_in_range   = ({1'b0, wr_idx_i} < NK);
  assign rd_in_range   = ({1'b0, rd_idx_i} < NK);
  assign rd_in_range_o = rd_in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        bank_q[i] <= '0;
      end
    end else if (wr_en_i && wr_in_range) begin
      bank_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Out-of-range reads return zero so the caller's XOR leaves data unchanged.
  always_comb begin
    rd_data_o = '0;
    if (rd_in_range) begin
      if (wr_en_i && (wr_idx_i == rd_idx_i)) begin
        rd_data_o = wr_data_i;
      end else begin
        rd_data_o = bank_q[rd_idx_i];
      end
    end
  end

endmodule

// File: rtl/add_round_key_seq.sv
// Lane-serial AddRoundKey: accepts a state and round index, snapshots the round
// key, XORs LANE_W bits per cycle and holds the result until it is taken.
module add_round_key_seq
  import aes_pkg::*;
#(
  parameter  int LANE_W   = 32,
  parameter  int NUM_KEYS = 15,
  localparam int KIDX_W   = $clog2(NUM_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_wr_en,
  input  logic [KIDX_W-1:0] key_wr_idx,
  input  aes_block_t        key_wr_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  aes_block_t        in_data,
  input  logic [KIDX_W-1:0] in_round,
  output logic              out_valid,
  input  logic              out_ready,
  output aes_block_t        out_data,
  output logic [KIDX_W-1:0] out_round,
  output logic              out_err,
  output ark_state_t        state_o
);

  localparam int BEATS = AES_BLOCK_W / LANE_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  if (!lane_w_valid(LANE_W)) begin : g_bad_lane_w
    $error("add_round_key_seq: LANE_W must be 8, 16, 32, 64 or 128");
  end

  // Handshakes: a transfer occurs on a rising edge where valid and ready are
  // both high; valid never waits on ready, and ready/valid depend on state only.

  ark_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  aes_block_t        work_q, work_d;
  aes_block_t        key_q, key_d;
  logic [KIDX_W-1:0] round_q, round_d;
  logic              err_q, err_d;
  aes_block_t        out_data_q, out_data_d;
  logic [KIDX_W-1:0] out_round_q, out_round_d;
  logic              out_err_q, out_err_d;

  aes_block_t        bank_rd;
  logic              bank_rd_in_range;

  round_key_bank #(
    .NUM_KEYS (NUM_KEYS)
  ) u_bank (
    .clk           (clk),
    .rst           (rst),
    .wr_en_i       (key_wr_en),
    .wr_idx_i      (key_wr_idx),
    .wr_data_i     (key_wr_data),
    .rd_idx_i      (in_round),
    .rd_data_o     (bank_rd),
    .rd_in_range_o (bank_rd_in_range)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      key_q       <= '0;
      round_q     <= '0;
      err_q       <= 1'b0;
      out_data_q  <= '0;
      out_round_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      key_q       <= key_d;
      round_q     <= round_d;
      err_q       <= err_d;
      out_data_q  <= out_data_d;
      out_round_q <= out_round_d;
      out_err_q   <= out_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    key_d       = key_q;
    round_d     = round_q;
    err_d       = err_q;
    out_data_d  = out_data_q;
    out_round_d = out_round_q;
    out_err_d   = out_err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          key_d   = bank_rd;
          round_d = in_round;
          err_d   = !bank_rd_in_range;
          cnt_d   = '0;
          state_d = XOR;
        end
      end
      XOR: begin
        for (int i = 0; i < BEATS; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            work_d[i*LANE_W +: LANE_W] = work_q[i*LANE_W +: LANE_W] ^ key_q[i*LANE_W +: LANE_W];
          end
        end
        // The output register captures the completed block on the final lane.
        if (cnt_q == LAST) begin
          out_data_d  = work_d;
          out_round_d = round_q;
          out_err_d   = err_q;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_round = out_round_q;
  assign out_err   = out_err_q;
  assign state_o   = state_q;

endmodule
